// File: rtl/id_stage_pipe.sv
// Decode stage for the 5-stage MIPS core: IF/ID and ID/EX registers, EXE/MEM operand
// forwarding, hazard interlock, ID-resolved BEQ/BNE/JR and a saturating stall counter.
module id_stage_pipe #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 24,
  parameter int FWD_EN = 1,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              if_valid,
  input  logic [31:0]       if_inst,
  input  logic [DATA_W-1:0] if_pc,
  output logic              id_ready,
  output logic [REG_AW-1:0] rs_addr,
  output logic [REG_AW-1:0] rt_addr,
  input  logic [DATA_W-1:0] qa,
  input  logic [DATA_W-1:0] qb,
  input  logic [CTRL_W-1:0] ctrl_bundle,
  input  logic              use_rs,
  input  logic              use_rt,
  input  logic              is_branch,
  input  logic              br_ne,
  input  logic              is_jr,
  input  logic              sext,
  input  logic              rd_or_rt,
  input  logic [REG_AW-1:0] exe_reg,
  input  logic [REG_AW-1:0] mem_reg,
  input  logic              exe_wreg,
  input  logic              exe_m2reg,
  input  logic              mem_wreg,
  input  logic              mem_m2reg,
  input  logic [DATA_W-1:0] exe_alu,
  input  logic [DATA_W-1:0] mem_alu,
  input  logic [DATA_W-1:0] mem_ldata,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [DATA_W-1:0] ex_da,
  output logic [DATA_W-1:0] ex_db,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc,
  output logic [REG_AW-1:0] ex_rn,
  output logic              redirect_valid,
  output logic [DATA_W-1:0] redirect_pc,
  output logic [STAT_W-1:0] stall_cnt
);

  logic              id_valid_q;
  logic [31:0]       id_inst_q;
  logic [DATA_W-1:0] id_pc_q;

  logic              ex_valid_q, redir_valid_q;
  logic [CTRL_W-1:0] ex_ctrl_q;
  logic [DATA_W-1:0] ex_da_q, ex_db_q, ex_imm_q, ex_pc_q, redir_pc_q;
  logic [REG_AW-1:0] ex_rn_q;
  logic [STAT_W-1:0] stall_q, stall_d;

  logic m_e_rs, m_e_rt, m_m_rs, m_m_rt, hazard, fire;
  logic [DATA_W-1:0] op_a, op_b, simm, zimm, imm_d, br_target, redir_pc_d;
  logic [REG_AW-1:0] rn_d;
  logic redir_d;

  logic unused_opcode;
  assign unused_opcode = ^id_inst_q[31:26];

  assign rs_addr = REG_AW'(id_inst_q[25:21]);
  assign rt_addr = REG_AW'(id_inst_q[20:16]);

  assign m_e_rs = use_rs && exe_wreg && (exe_reg == rs_addr) && (rs_addr != '0);
  assign m_e_rt = use_rt && exe_wreg && (exe_reg == rt_addr) && (rt_addr != '0);
  assign m_m_rs = use_rs && mem_wreg && (mem_reg == rs_addr) && (rs_addr != '0);
  assign m_m_rt = use_rt && mem_wreg && (mem_reg == rt_addr) && (rt_addr != '0);

  // Without forwarding the consumer waits until the producer has left MEM.
  assign hazard = (FWD_EN != 0) ? ((m_e_rs || m_e_rt) && exe_m2reg)
                                : (m_e_rs || m_e_rt || m_m_rs || m_m_rt);

  assign fire     = id_valid_q && !hazard && (!ex_valid_q || ex_ready);
  assign id_ready = !id_valid_q || fire;

  always_comb begin
    op_a = qa;
    op_b = qb;
    if (FWD_EN != 0) begin
      if (m_e_rs && !exe_m2reg) op_a = exe_alu;
      else if (m_m_rs)          op_a = mem_m2reg ? mem_ldata : mem_alu;
      if (m_e_rt && !exe_m2reg) op_b = exe_alu;
      else if (m_m_rt)          op_b = mem_m2reg ? mem_ldata : mem_alu;
    end
  end

  assign simm       = {{(DATA_W-16){id_inst_q[15]}}, id_inst_q[15:0]};
  assign zimm       = {{(DATA_W-16){1'b0}}, id_inst_q[15:0]};
  assign imm_d      = sext ? simm : zimm;
  assign rn_d       = rd_or_rt ? REG_AW'(id_inst_q[15:11]) : REG_AW'(id_inst_q[20:16]);
  assign br_target  = id_pc_q + DATA_W'(4) + (simm << 2);
  assign redir_d    = is_jr || (is_branch && ((op_a == op_b) ^ br_ne));
  assign redir_pc_d = is_jr ? op_a : br_target;

  always_comb begin
    stall_d = stall_q;
    if (id_valid_q && hazard && (stall_q != '1)) stall_d = stall_q + STAT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      id_valid_q <= 1'b0;
      id_inst_q  <= '0;
      id_pc_q    <= '0;
    end else if (flush) begin
      id_valid_q <= 1'b0;
    end else if (id_ready) begin
      id_valid_q <= if_valid;
      if (if_valid) begin
        id_inst_q <= if_inst;
        id_pc_q   <= if_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_q    <= 1'b0;
      ex_ctrl_q     <= '0;
      ex_da_q       <= '0;
      ex_db_q       <= '0;
      ex_imm_q      <= '0;
      ex_pc_q       <= '0;
      ex_rn_q       <= '0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
      stall_q       <= '0;
    end else if (flush) begin
      ex_valid_q    <= 1'b0;
      redir_valid_q <= 1'b0;
    end else begin
      stall_q <= stall_d;
      if (fire) begin
        ex_valid_q    <= 1'b1;
        ex_ctrl_q     <= ctrl_bundle;
        ex_da_q       <= op_a;
        ex_db_q       <= op_b;
        ex_imm_q      <= imm_d;
        ex_pc_q       <= id_pc_q;
        ex_rn_q       <= rn_d;
        redir_valid_q <= redir_d;
        redir_pc_q    <= redir_pc_d;
      end else begin
        if (ex_ready) ex_valid_q <= 1'b0;
        redir_valid_q <= 1'b0;
      end
    end
  end

  assign ex_valid       = ex_valid_q;
  assign ex_ctrl        = ex_ctrl_q;
  assign ex_da          = ex_da_q;
  assign ex_db          = ex_db_q;
  assign ex_imm         = ex_imm_q;
  assign ex_pc          = ex_pc_q;
  assign ex_rn          = ex_rn_q;
  assign redirect_valid = redir_valid_q;
  assign redirect_pc    = redir_pc_q;
  assign stall_cnt      = stall_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: a forwarding instance and an interlock-only instance
// share stimulus; expected values are hand-computed constants.
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        reset, flush, if_valid;
  logic [31:0] if_inst, if_pc, qa, qb;
  logic [23:0] ctrl_bundle;
  logic        use_rs, use_rt, is_branch, br_ne, is_jr, sext, rd_or_rt;
  logic [4:0]  exe_reg, mem_reg;
  logic        exe_wreg, exe_m2reg, mem_wreg, mem_m2reg, ex_ready;
  logic [31:0] exe_alu, mem_alu, mem_ldata;

  logic        id_ready, ex_valid, redirect_valid;
  logic [4:0]  rs_addr, rt_addr, ex_rn;
  logic [23:0] ex_ctrl;
  logic [31:0] ex_da, ex_db, ex_imm, ex_pc, redirect_pc;
  logic [15:0] stall_cnt;

  logic        id_ready0, ex_valid0, redirect_valid0;
  logic [4:0]  rs_addr0, rt_addr0, ex_rn0;
  logic [23:0] ex_ctrl0;
  logic [31:0] ex_da0, ex_db0, ex_imm0, ex_pc0, redirect_pc0;
  logic [15:0] stall_cnt0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_stage_pipe #(.FWD_EN(1)) dut (
    .clk(clk), .reset(reset), .flush(flush), .if_valid(if_valid), .if_inst(if_inst),
    .if_pc(if_pc), .id_ready(id_ready), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .qa(qa), .qb(qb), .ctrl_bundle(ctrl_bundle), .use_rs(use_rs), .use_rt(use_rt),
    .is_branch(is_branch), .br_ne(br_ne), .is_jr(is_jr), .sext(sext), .rd_or_rt(rd_or_rt),
    .exe_reg(exe_reg), .mem_reg(mem_reg), .exe_wreg(exe_wreg), .exe_m2reg(exe_m2reg),
    .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .exe_alu(exe_alu), .mem_alu(mem_alu),
    .mem_ldata(mem_ldata), .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
    .ex_da(ex_da), .ex_db(ex_db), .ex_imm(ex_imm), .ex_pc(ex_pc), .ex_rn(ex_rn),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall_cnt(stall_cnt)
  );

  id_stage_pipe #(.FWD_EN(0)) dut0 (
    .clk(clk), .reset(reset), .flush(flush), .if_valid(if_valid), .if_inst(if_inst),
    .if_pc(if_pc), .id_ready(id_ready0), .rs_addr(rs_addr0), .rt_addr(rt_addr0),
    .qa(qa), .qb(qb), .ctrl_bundle(ctrl_bundle), .use_rs(use_rs), .use_rt(use_rt),
    .is_branch(is_branch), .br_ne(br_ne), .is_jr(is_jr), .sext(sext), .rd_or_rt(rd_or_rt),
    .exe_reg(exe_reg), .mem_reg(mem_reg), .exe_wreg(exe_wreg), .exe_m2reg(exe_m2reg),
    .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .exe_alu(exe_alu), .mem_alu(mem_alu),
    .mem_ldata(mem_ldata), .ex_ready(ex_ready), .ex_valid(ex_valid0), .ex_ctrl(ex_ctrl0),
    .ex_da(ex_da0), .ex_db(ex_db0), .ex_imm(ex_imm0), .ex_pc(ex_pc0), .ex_rn(ex_rn0),
    .redirect_valid(redirect_valid0), .redirect_pc(redirect_pc0), .stall_cnt(stall_cnt0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    use_rs = 0; use_rt = 0; is_branch = 0; br_ne = 0; is_jr = 0; sext = 0; rd_or_rt = 0;
    exe_reg = 0; mem_reg = 0; exe_wreg = 0; exe_m2reg = 0; mem_wreg = 0; mem_m2reg = 0;
    exe_alu = 0; mem_alu = 0; mem_ldata = 0; qa = 0; qb = 0; ctrl_bundle = 0;
  endtask

  task automatic load_id(input logic [31:0] inst, input logic [31:0] pc);
    if_valid = 1; if_inst = inst; if_pc = pc;
    tick();
    if_valid = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; flush = 0; ex_ready = 1;
    if_valid = 1; if_inst = 32'h00221820; if_pc = 0;
    idle();
    tick(); tick();
    reset = 0; if_valid = 0;
    chk("rst_ex_valid", 32'(ex_valid), 0);
    chk("rst_redirect", 32'(redirect_valid), 0);
    chk("rst_stall", 32'(stall_cnt), 0);
    chk("rst_ex_da", ex_da, 0);
    chk("rst_ex_rn", 32'(ex_rn), 0);
    chk("rst_id_ready", 32'(id_ready), 1);
    chk("rst_ex_valid0", 32'(ex_valid0), 0);

    // add $3,$1,$2 then sub $4,$3,$1 (EXE wins over a stale MEM match)
    load_id(32'h00221820, 32'h0);
    if_valid = 1; if_inst = 32'h00612022; if_pc = 32'h4;
    use_rs = 1; use_rt = 1; rd_or_rt = 1; qa = 32'h1; qb = 32'h2;
    tick();
    if_valid = 0;
    chk("add_ex_valid", 32'(ex_valid), 1);
    chk("add_ex_rn", 32'(ex_rn), 3);
    qa = 32'hDEAD; qb = 32'h1;
    exe_reg = 3; exe_wreg = 1; exe_alu = 32'h10;
    mem_reg = 3; mem_wreg = 1; mem_alu = 32'h99;
    #1;
    chk("alu_dep_id_ready", 32'(id_ready), 1);
    tick();
    chk("alu_dep_ex_da", ex_da, 32'h10);
    chk("alu_dep_ex_db", ex_db, 32'h1);
    chk("alu_dep_ex_rn", 32'(ex_rn), 4);
    chk("alu_dep_ex_pc", ex_pc, 32'h4);
    chk("alu_dep_stall", 32'(stall_cnt), 0);
    idle();
    tick();
    chk("alu_dep_drain", 32'(ex_valid), 0);

    // load-use: lw $5 in EXE, add $6,$5,$0 in ID
    load_id(32'h00A03020, 32'h20);
    use_rs = 1; use_rt = 1; rd_or_rt = 1; qa = 32'h1111;
    exe_reg = 5; exe_wreg = 1; exe_m2reg = 1; exe_alu = 32'h40;
    #1;
    chk("lu_id_ready_stall", 32'(id_ready), 0);
    tick();
    chk("lu_bubble", 32'(ex_valid), 0);
    chk("lu_stall_cnt", 32'(stall_cnt), 1);
    exe_wreg = 0; exe_m2reg = 0;
    mem_reg = 5; mem_wreg = 1; mem_m2reg = 1; mem_ldata = 32'hCAFE; mem_alu = 32'h40;
    #1;
    chk("lu_id_ready_go", 32'(id_ready), 1);
    tick();
    chk("lu_ex_valid", 32'(ex_valid), 1);
    chk("lu_ex_da", ex_da, 32'hCAFE);
    chk("lu_ex_rn", 32'(ex_rn), 6);
    chk("lu_stall_after", 32'(stall_cnt), 1);
    idle();
    tick();

    // addi $7,$0,-16: register 0 never forwarded or stalled; sign-extended immediate
    load_id(32'h2007FFF0, 32'h40);
    use_rs = 1; sext = 1; qa = 32'h77; ctrl_bundle = 24'hA5A5A5;
    exe_reg = 0; exe_wreg = 1; exe_m2reg = 1; exe_alu = 32'h5;
    mem_reg = 0; mem_wreg = 1; mem_alu = 32'h6;
    #1;
    chk("r0_id_ready", 32'(id_ready), 1);
    tick();
    chk("r0_ex_da", ex_da, 32'h77);
    chk("r0_ex_imm", ex_imm, 32'hFFFFFFF0);
    chk("r0_ex_rn", 32'(ex_rn), 7);
    chk("r0_ex_ctrl", 32'(ex_ctrl), 32'h00A5A5A5);
    chk("r0_stall", 32'(stall_cnt), 1);
    idle();
    tick();

    // BEQ $8,$9,+4 at 0x100 on forwarded equal operands; delay slot nop follows
    load_id(32'h11090004, 32'h100);
    is_branch = 1; sext = 1; use_rs = 1; use_rt = 1; qa = 32'h1; qb = 32'h2;
    exe_reg = 8; exe_wreg = 1; exe_alu = 32'h55;
    mem_reg = 9; mem_wreg = 1; mem_alu = 32'h55;
    if_valid = 1; if_inst = 32'h0; if_pc = 32'h104;
    tick();
    if_valid = 0;
    chk("beq_redirect", 32'(redirect_valid), 1);
    chk("beq_target", redirect_pc, 32'h114);
    idle();
    tick();
    chk("beq_pulse_end", 32'(redirect_valid), 0);
    chk("slot_ex_valid", 32'(ex_valid), 1);
    chk("slot_ex_pc", ex_pc, 32'h104);
    tick();

    // BNE with the same equal operands: not taken
    load_id(32'h15090004, 32'h100);
    is_branch = 1; br_ne = 1; sext = 1; use_rs = 1; use_rt = 1; qa = 32'h1; qb = 32'h2;
    exe_reg = 8; exe_wreg = 1; exe_alu = 32'h55;
    mem_reg = 9; mem_wreg = 1; mem_alu = 32'h55;
    tick();
    chk("bne_no_redirect", 32'(redirect_valid), 0);
    chk("bne_fired", ex_pc, 32'h100);
    idle();
    tick();

    // JR $31
    load_id(32'h03E00008, 32'h180);
    is_jr = 1; use_rs = 1; qa = 32'h80000000;
    tick();
    chk("jr_redirect", 32'(redirect_valid), 1);
    chk("jr_target", redirect_pc, 32'h80000000);
    idle();
    tick();

    // ex_ready low for 3 cycles with an instruction waiting in ID
    load_id(32'h00221820, 32'h200);
    use_rs = 1; rd_or_rt = 1; qa = 32'hAAAA;
    if_valid = 1; if_inst = 32'h00612022; if_pc = 32'h204;
    tick();
    if_valid = 0; ex_ready = 0; qa = 32'hBBBB;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_id_ready", 32'(id_ready), 0);
      tick();
      chk("hold_ex_valid", 32'(ex_valid), 1);
      chk("hold_ex_pc", ex_pc, 32'h200);
      chk("hold_ex_da", ex_da, 32'hAAAA);
    end
    ex_ready = 1;
    #1;
    chk("hold_release_ready", 32'(id_ready), 1);
    tick();
    chk("hold_next_pc", ex_pc, 32'h204);
    chk("hold_next_da", ex_da, 32'hBBBB);
    idle();
    tick();
    chk("hold_no_dup", 32'(ex_valid), 0);

    // flush during a load-use stall with EX backpressured
    load_id(32'h00221820, 32'h300);
    use_rs = 1; rd_or_rt = 1;
    if_valid = 1; if_inst = 32'h00A03020; if_pc = 32'h304;
    tick();
    if_valid = 0; ex_ready = 0;
    exe_reg = 5; exe_wreg = 1; exe_m2reg = 1;
    #1;
    chk("fl_id_ready_stall", 32'(id_ready), 0);
    tick();
    chk("fl_stall_cnt", 32'(stall_cnt), 2);
    chk("fl_ex_held", ex_pc, 32'h300);
    flush = 1;
    tick();
    flush = 0;
    chk("fl_ex_valid", 32'(ex_valid), 0);
    chk("fl_stall_hold", 32'(stall_cnt), 2);
    chk("fl_redirect", 32'(redirect_valid), 0);
    #1;
    chk("fl_id_empty", 32'(id_ready), 1);
    idle();
    ex_ready = 1;

    // reset together with flush and if_valid: reset wins
    reset = 1; flush = 1; if_valid = 1; if_inst = 32'h00221820; if_pc = 32'h400;
    tick();
    reset = 0; flush = 0; if_valid = 0;
    chk("rf_ex_valid", 32'(ex_valid), 0);
    chk("rf_stall", 32'(stall_cnt), 0);
    chk("rf_ex_pc", ex_pc, 0);
    chk("rf_ex_da", ex_da, 0);
    chk("rf_ex_imm", ex_imm, 0);
    chk("rf_ex_rn", 32'(ex_rn), 0);
    chk("rf_ex_ctrl", 32'(ex_ctrl), 0);
    chk("rf_redirect_pc", redirect_pc, 0);
    tick();
    chk("rf_id_was_empty", 32'(ex_valid), 0);

    // interlock-only instance: add then dependent sub stalls through EXE and MEM
    load_id(32'h00221820, 32'h0);
    if_valid = 1; if_inst = 32'h00612022; if_pc = 32'h4;
    use_rs = 1; use_rt = 1; rd_or_rt = 1; qa = 32'h1; qb = 32'h2;
    tick();
    if_valid = 0;
    qa = 32'hBAD; qb = 32'h1;
    exe_reg = 3; exe_wreg = 1; exe_alu = 32'h10;
    #1;
    chk("nf_stall_exe", 32'(id_ready0), 0);
    tick();
    chk("nf_bubble", 32'(ex_valid0), 0);
    chk("nf_stall_cnt1", 32'(stall_cnt0), 1);
    exe_wreg = 0;
    mem_reg = 3; mem_wreg = 1; mem_alu = 32'h10;
    #1;
    chk("nf_stall_mem", 32'(id_ready0), 0);
    tick();
    mem_wreg = 0; qa = 32'h10;
    #1;
    chk("nf_go", 32'(id_ready0), 1);
    tick();
    chk("nf_ex_valid", 32'(ex_valid0), 1);
    chk("nf_ex_da", ex_da0, 32'h10);
    chk("nf_ex_rn", 32'(ex_rn0), 4);
    chk("nf_stall_cnt2", 32'(stall_cnt0), 2);
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised decode-stage successor for the 5-stage MIPS core.
- Owns the IF/ID and ID/EX pipeline registers and full operand forwarding (EXE/MEM), replacing the tied-off forwarding muxes.
- Detects load-use and non-forwardable hazards and stalls upstream with a valid/ready handshake.
- Resolves BEQ/BNE/JR in ID on forwarded operands and counts stall cycles. Decode fields come from the existing control unit via ctrl_* ports.

Parameters:
- DATA_W, 32, datapath/register width.
- REG_AW, 5, register-address width; address 0 is hardwired zero.
- CTRL_W, 24, width of opaque control bundle passed to EX (ALUControl, mem_control, flags).
- FWD_EN, 1, 1 = EXE/MEM forwarding; 0 = interlock-only (stall until producer retires past MEM).
- STAT_W, 16, stall-counter width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  kill IF/ID and ID/EX contents (exception)
- if_valid  in  1  IF presents instruction
- if_inst  in  32  instruction
- if_pc  in  DATA_W  its PC
- id_ready  out  1  ID can accept from IF this cycle
- rs_addr, rt_addr  out  REG_AW each  regfile read addresses (from IF/ID reg inst[25:21], inst[20:16])
- qa, qb  in  DATA_W each  regfile read data (combinational)
- ctrl_bundle  in  CTRL_W  control-unit decode of held instruction
- use_rs, use_rt, is_branch, br_ne, is_jr, sext, rd_or_rt  in  1 each  control-unit decode flags
- exe_reg, mem_reg  in  REG_AW each  destination regs in EXE/MEM
- exe_wreg, exe_m2reg, mem_wreg, mem_m2reg  in  1 each  write/load flags
- exe_alu, mem_alu, mem_ldata  in  DATA_W each  forwardable results
- ex_ready  in  1  EX accepts ID/EX contents
- ex_valid  out  1  ID/EX valid
- ex_ctrl  out  CTRL_W
- ex_da, ex_db, ex_imm, ex_pc  out  DATA_W each
- ex_rn  out  REG_AW
- redirect_valid  out  1  branch/jump taken (1-cycle pulse)
- redirect_pc  out  DATA_W
- stall_cnt  out  STAT_W  saturating count of hazard-stall cycles

Behaviour:
- Reset (sync, priority over all): id_valid, ex_valid, redirect_valid = 0; all ID/EX data, ex_rn, stall_cnt = 0.
- flush (next priority): id_valid, ex_valid = 0 next cycle; redirect_valid = 0; stall_cnt holds.
- Match rules: matchE(r) = exe_wreg && exe_reg==r && r!=0; matchM(r) analogous with mem_*. Only used sources (use_rs/use_rt) count.
- FWD_EN=1: operand = exe_alu if matchE && !exe_m2reg; else mem_ldata if matchM && mem_m2reg; else mem_alu if matchM; else qa/qb. EXE beats MEM.
- FWD_EN=1 hazard: matchE && exe_m2reg (load-use) → 1 stall cycle.
- FWD_EN=0: hazard on any matchE or matchM; operand always qa/qb.
- fire = id_valid && !hazard && (!ex_valid || ex_ready). id_ready = !id_valid || fire.
- IF/ID loads if_inst/if_pc when if_valid && id_ready; id_valid <= if_valid if id_ready, else holds.
- ID/EX load on fire: ex_valid=1; ex_da/ex_db = forwarded operands; ex_imm = sext ? sign-ext inst[15:0] : zero-ext; ex_rn = rd_or_rt ? inst[15:11] : inst[20:16]; ex_pc, ex_ctrl copied.
- ID/EX when !fire: if ex_ready, ex_valid <= 0 (bubble); else hold all.
- Branch (registered, asserted cycle after fire): taken = is_branch && ((da==db) ^ br_ne); redirect_pc = pc+4+(sext_imm<<2). is_jr: redirect_pc = da.
- Delay slot: instruction after a branch is not flushed.
- stall_cnt increments each cycle id_valid && hazard; saturates at all-ones.
- Simultaneous reset+flush: reset wins. Register 0 never forwarded or stalled.

Test Plan:
- Back-to-back ALU dependency: add $3,$1,$2 (exe_alu=0x10) then sub $4,$3,$1, FWD_EN=1 → ex_da=0x10, no stall, stall_cnt=0.
- Load-use: lw $5 in EXE (exe_m2reg=1), next uses $5 → id_ready=0 and ex_valid bubble for exactly 1 cycle; then ex_da=mem_ldata=0xCAFE; stall_cnt=1.
- FWD_EN=0 build, same ALU dependency → 2 stall cycles (EXE then MEM), ex_da=qa afterwards; stall_cnt=2.
- BEQ at pc 0x100, forwarded operands equal, imm=0x0004 → redirect_valid pulse 1 cycle, redirect_pc=0x114. BNE with same operands → no redirect. JR with da=0x8000_0000 → redirect_pc=0x8000_0000.
- ex_ready=0 for 3 cycles with instruction in ID → ID/EX contents held bit-exact; id_ready=0; no instruction lost or duplicated.
- flush mid-stall, then reset asserted together with if_valid → ex_valid=0, id_valid=0 next cycle; all outputs at reset values.
